// File: rtl/count_seq_pkg.sv
// ---------------------------------------------------------------------------
// count_seq_pkg
//
// Shared definitions for the count_macro sequencer:
//   - COUNT_W     : width of the analog count_macro's count bus
//   - SYNC_STAGES : depth of the synchroniser on that bus
//   - state_t     : sequencer state encoding
//   - max_int()   : elaboration-time helper for sizing the shared timer
// ---------------------------------------------------------------------------
package count_seq_pkg;

    localparam int COUNT_W     = 4;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [3:0] {
        IDLE,
        RESET,
        RELEASE,
        CHECK0,
        HIGH,
        LOW,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/count_seq_sync.sv
// ---------------------------------------------------------------------------
// count_seq_sync
//
// Two-flop synchroniser that brings the count_macro's count bus, which is
// launched from the macro clock, into the system clock domain. The bus is
// only ever sampled after a settle interval, so the bits are stable when
// used and per-bit synchronisation cannot produce a torn word.
//
// Ports:
//   clk    in  1        system clock
//   rst_n  in  1        synchronous active-low reset (flops clear to 0)
//   d      in  COUNT_W  asynchronous count bus from the macro
//   q      out COUNT_W  synchronised count
// ---------------------------------------------------------------------------
module count_seq_sync
    import count_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COUNT_W-1:0] d,
    output logic [COUNT_W-1:0] q
);

    logic [COUNT_W-1:0] meta;

    // NOTE: non-blocking assignments make both stages sample their inputs
    // before either updates; blocking ones would collapse the chain to one flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/count_macro_sequencer.sv
// ---------------------------------------------------------------------------
// count_macro_sequencer
//
// Exercises the analog-domain 4-bit count_macro: holds it in reset, releases
// it, checks it reads 0, then issues n_pulses clock pulses on its clock pin
// and checks the synchronised count after each one against the pulse index
// (mod 16). Reports a saturating mismatch tally and a pass flag per burst.
//
// Optional feature (compile-time macro COUNT_SEQ_ERRLOG_EN):
//   adds first_err_idx / first_err_val, the pulse index (CHECK0 = 0) and
//   observed value of the first mismatch in the burst.
//
// Ports:
//   clk            in  1        system clock (only clock)
//   rst_n          in  1        synchronous active-low reset
//   start          in  1        burst request, honoured only when idle
//   n_pulses       in  BURST_W  pulses per burst, latched on accepted start
//   half_period    in  DIV_W    macro clock phase length - 1, latched on start
//   macro_clk      out 1        macro clock pin (registered)
//   macro_reset_n  out 1        macro reset pin, active-low (registered)
//   macro_count    in  4        macro count bus, asynchronous
//   busy           out 1        burst in progress
//   done           out 1        one-cycle completion pulse
//   pass           out 1        last burst had no mismatches
//   err_count      out BURST_W  mismatches in last burst, saturating
//   last_count     out 4        most recent synchronised sample
//   first_err_idx  out BURST_W  (COUNT_SEQ_ERRLOG_EN only)
//   first_err_val  out 4        (COUNT_SEQ_ERRLOG_EN only)
// ---------------------------------------------------------------------------
module count_macro_sequencer
    import count_seq_pkg::*;
#(
    parameter int BURST_W    = 8,
    parameter int DIV_W      = 8,
    parameter int SETTLE_CYC = 4,
    parameter int RESET_CYC  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BURST_W-1:0] n_pulses,
    input  logic [DIV_W-1:0]   half_period,
    output logic               macro_clk,
    output logic               macro_reset_n,
    input  logic [COUNT_W-1:0] macro_count,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [BURST_W-1:0] err_count,
    output logic [COUNT_W-1:0] last_count
`ifdef COUNT_SEQ_ERRLOG_EN
    ,
    output logic [BURST_W-1:0] first_err_idx,
    output logic [COUNT_W-1:0] first_err_val
`endif
);

    // Settle interval covers the synchroniser latency plus analog settling.
    localparam int WAIT_CYC = SYNC_STAGES + SETTLE_CYC;

    // One down-counter times every phase, so it must hold the longest of
    // the fixed intervals and the programmable half period.
    localparam int FIX_W = $clog2(max_int(RESET_CYC, WAIT_CYC) + 1);
    localparam int TMR_W = max_int(DIV_W, FIX_W);

    state_t             state;
    state_t             next_state;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-1:0]   timer_load;
    logic [BURST_W-1:0] n_pulses_q;
    logic [DIV_W-1:0]   half_period_q;
    logic [BURST_W-1:0] pulse_idx;
    logic [COUNT_W-1:0] count_sync;
    logic               start_accept;
    logic               check_en;
    logic               mismatch;
    logic               timer_zero;

    count_seq_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (macro_count),
        .q     (count_sync)
    );

    assign start_accept = (state == IDLE) && start;
    assign timer_zero   = (timer == '0);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: assigning next_state a default before the case keeps every path
    // driven, so no latch is inferred for states that simply hold.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start)      next_state = RESET;
            RESET:   if (timer_zero) next_state = RELEASE;
            RELEASE: if (timer_zero) next_state = CHECK0;
            CHECK0:  next_state = (n_pulses_q == '0) ? DONE : HIGH;
            HIGH:    if (timer_zero) next_state = LOW;
            LOW:     if (timer_zero) next_state = WAIT;
            WAIT:    if (timer_zero) next_state = SAMPLE;
            SAMPLE:  next_state = (pulse_idx == n_pulses_q) ? DONE : HIGH;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        check_en = 1'b0;
        unique case (state)
            IDLE:           ;
            DONE:           done = 1'b1;
            CHECK0, SAMPLE: begin
                busy     = 1'b1;
                check_en = 1'b1;
            end
            default:        busy = 1'b1;
        endcase
    end

    // pulse_idx is 0 during CHECK0, so one expression covers both checks;
    // the truncation to COUNT_W gives the 15 -> 0 wrap of the macro.
    assign mismatch = check_en && (count_sync != pulse_idx[COUNT_W-1:0]);

    // -----------------------------------------------------------------------
    // Shared phase/settle timer: loaded with (duration - 1) on entry to a
    // timed state, then counts down; the state exits when it reads zero.
    // -----------------------------------------------------------------------
    always_comb begin
        timer_load = '0;
        unique case (next_state)
            RESET:         timer_load = TMR_W'(RESET_CYC - 1);
            RELEASE, WAIT: timer_load = TMR_W'(WAIT_CYC - 1);
            HIGH, LOW:     timer_load = TMR_W'(half_period_q);
            default:       timer_load = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (next_state != state) begin
            timer <= timer_load;
        end else if (!timer_zero) begin
            timer <= timer - 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Macro pins come straight from flops, decoded from next_state so they
    // line up exactly with the state they belong to and cannot glitch.
    // macro_reset_n holds its value outside RESET/RELEASE, which keeps the
    // macro out of reset in IDLE after a burst while power-up leaves it held.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            macro_clk     <= 1'b0;
            macro_reset_n <= 1'b0;
        end else begin
            macro_clk <= (next_state == HIGH);
            if (next_state == RESET) begin
                macro_reset_n <= 1'b0;
            end else if (next_state == RELEASE) begin
                macro_reset_n <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Burst parameters, pulse index and result registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_pulses_q    <= '0;
            half_period_q <= '0;
            pulse_idx     <= '0;
            err_count     <= '0;
            pass          <= 1'b0;
            last_count    <= '0;
        end else if (start_accept) begin
            n_pulses_q    <= n_pulses;
            half_period_q <= half_period;
            pulse_idx     <= '0;
            err_count     <= '0;
            pass          <= 1'b0;
        end else begin
            // Count a pulse as it ends its high phase, so SAMPLE sees 1..n.
            if (state == HIGH && next_state == LOW) begin
                pulse_idx <= pulse_idx + 1'b1;
            end
            if (check_en) begin
                last_count <= count_sync;
                if (mismatch && err_count != {BURST_W{1'b1}}) begin
                    err_count <= err_count + 1'b1;
                end
            end
            // DONE is only reached from CHECK0/SAMPLE, so the verdict folds
            // in that final comparison and is valid alongside done.
            if (next_state == DONE) begin
                pass <= (err_count == '0) && !mismatch;
            end
        end
    end

`ifdef COUNT_SEQ_ERRLOG_EN
    // First mismatch of the burst: err_count is still zero only until it
    // is recorded, and it is cleared again on the next accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_err_idx <= '0;
            first_err_val <= '0;
        end else if (start_accept) begin
            first_err_idx <= '0;
            first_err_val <= '0;
        end else if (mismatch && err_count == '0) begin
            first_err_idx <= pulse_idx;
            first_err_val <= count_sync;
        end
    end
`endif

endmodule

// File: tb/tb_count_macro_sequencer.sv
// ---------------------------------------------------------------------------
// tb_count_macro_sequencer
//
// Drives the sequencer against a behavioural model of the count_macro (with
// optional dropped-pulse and stuck-value faults). Directed bursts come from
// a table of hand-derived results; random bursts are scored against a
// reference model that derives the observed sequence and the expected
// results directly from the pulse count and fault type.
// Define COUNT_SEQ_ERRLOG_EN to also check the first-error log.
// ---------------------------------------------------------------------------
module tb_count_macro_sequencer;

    localparam int BURST_W    = 8;
    localparam int DIV_W      = 8;
    localparam int SETTLE_CYC = 4;
    localparam int RESET_CYC  = 8;
    localparam int MAX_CYC    = 4000;

    localparam int M_IDEAL = 0;
    localparam int M_DROP  = 1;
    localparam int M_STUCK = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [BURST_W-1:0] n_pulses = '0;
    logic [DIV_W-1:0]   half_period = '0;
    logic               macro_clk;
    logic               macro_reset_n;
    logic [3:0]         macro_count;
    logic               busy;
    logic               done;
    logic               pass;
    logic [BURST_W-1:0] err_count;
    logic [3:0]         last_count;
`ifdef COUNT_SEQ_ERRLOG_EN
    logic [BURST_W-1:0] first_err_idx;
    logic [3:0]         first_err_val;
`endif

    count_macro_sequencer #(
        .BURST_W    (BURST_W),
        .DIV_W      (DIV_W),
        .SETTLE_CYC (SETTLE_CYC),
        .RESET_CYC  (RESET_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .n_pulses      (n_pulses),
        .half_period   (half_period),
        .macro_clk     (macro_clk),
        .macro_reset_n (macro_reset_n),
        .macro_count   (macro_count),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .last_count    (last_count)
`ifdef COUNT_SEQ_ERRLOG_EN
        ,
        .first_err_idx (first_err_idx),
        .first_err_val (first_err_val)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- count_macro model ----------------
    int         fault_mode = M_IDEAL;
    int         fault_arg  = 0;
    logic [3:0] mac_cnt    = 4'd0;
    int         mac_pulses = 0;

    always @(posedge macro_clk or negedge macro_reset_n) begin
        if (!macro_reset_n) begin
            mac_cnt    <= 4'd0;
            mac_pulses <= 0;
        end else begin
            mac_pulses <= mac_pulses + 1;
            if (!(fault_mode == M_DROP && mac_pulses + 1 == fault_arg))
                mac_cnt <= mac_cnt + 4'd1;
        end
    end

    assign macro_count = (fault_mode == M_STUCK) ? 4'(fault_arg) : mac_cnt;

    int done_seen = 0;
    always @(negedge clk) begin
        if (done === 1'b1) done_seen <= done_seen + 1;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    typedef struct {
        int n;
        int h;
        int mode;
        int arg;
        bit restart;
        int exp_err;
        bit exp_pass;
        int exp_last;
        int exp_cycles;
        int exp_fidx;
        int exp_fval;
    } vec_t;

    // Reference: value read back after check i (0 = post-reset check).
    function automatic int observed(input int i, input int mode, input int arg);
        if (mode == M_STUCK) return arg;
        if (mode == M_DROP && arg >= 1 && i >= arg) return (i - 1) % 16;
        return i % 16;
    endfunction

    function automatic vec_t model(input int n, input int h, input int mode, input int arg);
        vec_t r;
        r.n = n; r.h = h; r.mode = mode; r.arg = arg; r.restart = 1'b0;
        r.exp_err = 0; r.exp_fidx = 0; r.exp_fval = 0;
        for (int i = 0; i <= n; i++) begin
            int obs = observed(i, mode, arg);
            if (obs != i % 16) begin
                if (r.exp_err == 0) begin
                    r.exp_fidx = i;
                    r.exp_fval = obs;
                end
                if (r.exp_err < (1 << BURST_W) - 1) r.exp_err++;
            end
        end
        r.exp_pass   = (r.exp_err == 0);
        r.exp_last   = observed(n, mode, arg);
        r.exp_cycles = RESET_CYC + (2 + SETTLE_CYC) + 1
                     + n * (2 * (h + 1) + 2 + SETTLE_CYC + 1) + 1;
        return r;
    endfunction

    task automatic run_burst(input vec_t v, input string tag);
        int cyc;
        int done_before;
        fault_mode = v.mode;
        fault_arg  = v.arg;
        @(negedge clk);
        n_pulses    = BURST_W'(v.n);
        half_period = DIV_W'(v.h);
        start       = 1'b1;
        done_before = done_seen;
        @(negedge clk);
        // Scramble the request inputs: the burst must use latched values.
        start       = 1'b0;
        n_pulses    = BURST_W'($urandom_range(0, 3));
        half_period = DIV_W'($urandom_range(0, 3));
        cyc = 1;
        check({tag, " busy after start"}, 32'(busy), 32'd1);
        check({tag, " macro_reset_n after start"}, 32'(macro_reset_n), 32'd0);
        while (done !== 1'b1 && cyc < MAX_CYC) begin
            @(negedge clk);
            cyc++;
            start = v.restart && (cyc == 20);
        end
        start = 1'b0;
        check({tag, " cycles to done"}, 32'(cyc), 32'(v.exp_cycles));
        check({tag, " busy at done"}, 32'(busy), 32'd0);
        check({tag, " err_count"}, 32'(err_count), 32'(v.exp_err));
        check({tag, " pass"}, 32'(pass), 32'(v.exp_pass));
        check({tag, " last_count"}, 32'(last_count), 32'(v.exp_last));
`ifdef COUNT_SEQ_ERRLOG_EN
        check({tag, " first_err_idx"}, 32'(first_err_idx), 32'(v.exp_fidx));
        check({tag, " first_err_val"}, 32'(first_err_val), 32'(v.exp_fval));
`endif
        @(negedge clk);
        check({tag, " done one cycle"}, 32'(done), 32'd0);
        check({tag, " pass held"}, 32'(pass), 32'(v.exp_pass));
        check({tag, " idle macro_reset_n"}, 32'(macro_reset_n), 32'd1);
        check({tag, " idle macro_clk"}, 32'(macro_clk), 32'd0);
        repeat (30) @(negedge clk);
        check({tag, " single done"}, 32'(done_seen - done_before), 32'd1);
    endtask

    vec_t vecs[5];

    initial begin
        int guard;
        vecs[0] = '{n:5,  h:1, mode:M_IDEAL, arg:0, restart:0, exp_err:0, exp_pass:1,
                    exp_last:5, exp_cycles:71, exp_fidx:0, exp_fval:0};
        vecs[1] = '{n:20, h:0, mode:M_IDEAL, arg:0, restart:0, exp_err:0, exp_pass:1,
                    exp_last:4, exp_cycles:196, exp_fidx:0, exp_fval:0};
        vecs[2] = '{n:6,  h:2, mode:M_DROP,  arg:3, restart:0, exp_err:4, exp_pass:0,
                    exp_last:5, exp_cycles:94, exp_fidx:3, exp_fval:2};
        vecs[3] = '{n:0,  h:1, mode:M_STUCK, arg:7, restart:0, exp_err:1, exp_pass:0,
                    exp_last:7, exp_cycles:16, exp_fidx:0, exp_fval:7};
        vecs[4] = '{n:7,  h:1, mode:M_IDEAL, arg:0, restart:1, exp_err:0, exp_pass:1,
                    exp_last:7, exp_cycles:93, exp_fidx:0, exp_fval:0};

        // Reset values
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset pass", 32'(pass), 32'd0);
        check("reset err_count", 32'(err_count), 32'd0);
        check("reset last_count", 32'(last_count), 32'd0);
        check("reset macro_clk", 32'(macro_clk), 32'd0);
        check("reset macro_reset_n", 32'(macro_reset_n), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_burst(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a HIGH phase aborts the burst.
        fault_mode = M_IDEAL;
        @(negedge clk);
        n_pulses = 8'd5; half_period = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (macro_clk !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("midreset reached HIGH", 32'(macro_clk), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset pass", 32'(pass), 32'd0);
        check("midreset err_count", 32'(err_count), 32'd0);
        check("midreset last_count", 32'(last_count), 32'd0);
        check("midreset macro_clk", 32'(macro_clk), 32'd0);
        check("midreset macro_reset_n", 32'(macro_reset_n), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_burst(vecs[0], "after_reset");

        // Random bursts scored by the reference model.
        for (int k = 0; k < 8; k++) begin
            int n    = int'($urandom_range(0, 40));
            int h    = int'($urandom_range(0, 3));
            int mode = int'($urandom_range(0, 2));
            int arg  = 0;
            if (mode == M_DROP)  arg = int'($urandom_range(1, (n > 0) ? n : 1));
            if (mode == M_STUCK) arg = int'($urandom_range(0, 15));
            run_burst(model(n, h, mode, arg), $sformatf("rand%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
